// File: rtl/store_req_unit.sv
// -----------------------------------------------------------------------------
// store_req_unit
//
// Store-side bus master for the MEM stage. It takes a store (sb/sh/sw), checks
// its alignment, and builds the byte enables and lane-aligned write data. It
// then issues one write request on the data bus with a req/ack handshake. A
// request that gets no acknowledge within TIMEOUT cycles is aborted.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   st_valid   in   store request present this cycle
//   st_type    in   2'b00 none, 2'b01 sb, 2'b10 sh, 2'b11 sw
//   st_addr    in   byte address of the store
//   st_wdata   in   register data (low byte / halfword used for sb / sh)
//   st_ready   out  unit can accept a request (IDLE decode)
//   st_done    out  one-cycle pulse when the bus acknowledges the write
//   exc_ades   out  one-cycle pulse on a misaligned store
//   exc_addr   out  faulting address, held until the next exception
//   bus_err    out  one-cycle pulse on timeout abort
//   m_req      out  write request to the bus
//   m_addr     out  word address of the store
//   m_byteen   out  byte enables
//   m_wdata    out  lane-aligned write data
//   m_ack      in   bus write acknowledge
// -----------------------------------------------------------------------------
module store_req_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_ready,
    output logic        st_done,
    output logic        exc_ades,
    output logic [31:0] exc_addr,
    output logic        bus_err,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic        m_ack
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;
    localparam logic [1:0] ST_SW = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Byte enables for an aligned store.
    function automatic logic [3:0] calc_byteen(input logic [1:0] typ,
                                               input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (typ)
            ST_SB:   be = 4'b0001 << a;
            ST_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            ST_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Write data moved into its byte lane(s); unused lanes are zero.
    function automatic logic [31:0] calc_wdata(input logic [1:0]  typ,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
        logic [31:0] wd;
        wd = 32'd0;
        case (typ)
            ST_SB:   wd = {24'd0, d[7:0]} << {a, 3'b000};
            ST_SH:   wd = a[1] ? {d[15:0], 16'd0} : {16'd0, d[15:0]};
            ST_SW:   wd = d;
            default: wd = 32'd0;
        endcase
        return wd;
    endfunction

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             m_req_q,    m_req_d;
    logic [31:0]      m_addr_q,   m_addr_d;
    logic [3:0]       m_byteen_q, m_byteen_d;
    logic [31:0]      m_wdata_q,  m_wdata_d;
    logic             st_done_q,  st_done_d;
    logic             exc_ades_q, exc_ades_d;
    logic [31:0]      exc_addr_q, exc_addr_d;
    logic             bus_err_q,  bus_err_d;

    logic accept;
    logic misalign;

    assign accept   = (state_q == IDLE) && st_valid && (st_type != 2'b00);
    assign misalign = ((st_type == ST_SH) && st_addr[0]) ||
                      ((st_type == ST_SW) && (st_addr[1:0] != 2'b00));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_addr_d   = m_addr_q;
        m_byteen_d = m_byteen_q;
        m_wdata_d  = m_wdata_q;
        st_done_d  = 1'b0;
        exc_ades_d = 1'b0;
        exc_addr_d = exc_addr_q;
        bus_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // m_ack is deliberately not looked at here.
                if (accept) begin
                    if (misalign) begin
                        // Bus outputs keep their previous values on a fault.
                        exc_ades_d = 1'b1;
                        exc_addr_d = st_addr;
                    end else begin
                        state_d    = BUSY;
                        cnt_d      = '0;
                        m_req_d    = 1'b1;
                        m_addr_d   = {st_addr[31:2], 2'b00};
                        m_byteen_d = calc_byteen(st_type, st_addr[1:0]);
                        m_wdata_d  = calc_wdata(st_type, st_addr[1:0], st_wdata);
                    end
                end
            end
            BUSY: begin
                // Acknowledge takes priority over the timeout limit.
                if (m_ack) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    m_byteen_d = 4'b0000;
                    st_done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    m_req_d    = 1'b0;
                    m_byteen_d = 4'b0000;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_req_q    <= 1'b0;
            m_addr_q   <= 32'd0;
            m_byteen_q <= 4'b0000;
            m_wdata_q  <= 32'd0;
            st_done_q  <= 1'b0;
            exc_ades_q <= 1'b0;
            exc_addr_q <= 32'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_addr_q   <= m_addr_d;
            m_byteen_q <= m_byteen_d;
            m_wdata_q  <= m_wdata_d;
            st_done_q  <= st_done_d;
            exc_ades_q <= exc_ades_d;
            exc_addr_q <= exc_addr_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign st_ready = (state_q == IDLE);
    assign st_done  = st_done_q;
    assign exc_ades = exc_ades_q;
    assign exc_addr = exc_addr_q;
    assign bus_err  = bus_err_q;
    assign m_req    = m_req_q;
    assign m_addr   = m_addr_q;
    assign m_byteen = m_byteen_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_store_req_unit.sv
// -----------------------------------------------------------------------------
// tb_store_req_unit
//
// Directed bench for store_req_unit. Inputs change on the falling clock edge,
// and outputs are sampled on the falling edge before any inputs change.
// -----------------------------------------------------------------------------
module tb_store_req_unit;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        st_done;
    logic        exc_ades;
    logic [31:0] exc_addr;
    logic        bus_err;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_byteen;
    logic [31:0] m_wdata;
    logic        m_ack;

    int total;
    int bad;

    store_req_unit #(
        .TIMEOUT(16),
        .CNT_W  (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .st_valid(st_valid),
        .st_type (st_type),
        .st_addr (st_addr),
        .st_wdata(st_wdata),
        .st_ready(st_ready),
        .st_done (st_done),
        .exc_ades(exc_ades),
        .exc_addr(exc_addr),
        .bus_err (bus_err),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_byteen(m_byteen),
        .m_wdata (m_wdata),
        .m_ack   (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] typ, input logic [31:0] a,
                         input logic [31:0] d);
        st_valid = 1'b1;
        st_type  = typ;
        st_addr  = a;
        st_wdata = d;
    endtask

    task automatic idle_in();
        st_valid = 1'b0;
        st_type  = 2'b00;
        st_addr  = 32'd0;
        st_wdata = 32'd0;
    endtask

    initial begin
        int hi_cnt;
        int err_cnt;
        int done_cnt;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        m_ack = 1'b0;
        idle_in();

        // Reset state.
        tick();
        chk("rst_ready",  32'(st_ready), 32'd1);
        chk("rst_req",    32'(m_req),    32'd0);
        chk("rst_byteen", 32'(m_byteen), 32'd0);
        chk("rst_done",   32'(st_done),  32'd0);
        chk("rst_ades",   32'(exc_ades), 32'd0);
        chk("rst_buserr", 32'(bus_err),  32'd0);
        reset = 1'b1;
        tick();

        // sb at 0x1002 with ack tied high.
        m_ack = 1'b1;
        drive(2'b01, 32'h0000_1002, 32'hAABB_CCDD);
        tick();
        idle_in();
        chk("sb_req",    32'(m_req),    32'd1);
        chk("sb_addr",   m_addr,        32'h0000_1000);
        chk("sb_byteen", 32'(m_byteen), 32'h4);
        chk("sb_wdata",  m_wdata,       32'h00DD_0000);
        chk("sb_ready",  32'(st_ready), 32'd0);
        tick();
        chk("sb_req_off", 32'(m_req),    32'd0);
        chk("sb_done",    32'(st_done),  32'd1);
        chk("sb_ready2",  32'(st_ready), 32'd1);
        tick();
        chk("sb_done_pulse", 32'(st_done), 32'd0);

        // sh at 0x42, acknowledged in the third BUSY cycle.
        m_ack = 1'b0;
        drive(2'b10, 32'h0000_0042, 32'h1234_5678);
        tick();
        idle_in();
        chk("sh_addr",   m_addr,        32'h0000_0040);
        chk("sh_byteen", 32'(m_byteen), 32'hC);
        chk("sh_wdata",  m_wdata,       32'h5678_0000);
        for (int i = 1; i <= 3; i++) begin
            chk("sh_req_hi",  32'(m_req),    32'd1);
            chk("sh_busy_rd", 32'(st_ready), 32'd0);
            if (i == 3) m_ack = 1'b1;
            tick();
        end
        m_ack = 1'b0;
        chk("sh_req_off", 32'(m_req),    32'd0);
        chk("sh_byteen0", 32'(m_byteen), 32'd0);
        chk("sh_done",    32'(st_done),  32'd1);

        // Misaligned sw and sh.
        tick();
        drive(2'b11, 32'h0000_0006, 32'hDEAD_BEEF);
        tick();
        idle_in();
        chk("sw_mis_ades",  32'(exc_ades), 32'd1);
        chk("sw_mis_addr",  exc_addr,      32'h0000_0006);
        chk("sw_mis_req",   32'(m_req),    32'd0);
        chk("sw_mis_ready", 32'(st_ready), 32'd1);
        chk("sw_mis_wdata", m_wdata,       32'h5678_0000);
        tick();
        chk("sw_mis_pulse", 32'(exc_ades), 32'd0);
        chk("sw_mis_hold",  exc_addr,      32'h0000_0006);
        chk("sw_mis_req2",  32'(m_req),    32'd0);
        drive(2'b10, 32'h0000_0003, 32'h0000_1111);
        tick();
        idle_in();
        chk("sh_mis_ades", 32'(exc_ades), 32'd1);
        chk("sh_mis_addr", exc_addr,      32'h0000_0003);
        chk("sh_mis_req",  32'(m_req),    32'd0);
        tick();
        chk("sh_mis_pulse", 32'(exc_ades), 32'd0);

        // st_valid with type none is ignored.
        drive(2'b00, 32'h0000_0100, 32'h1);
        tick();
        idle_in();
        chk("none_req",   32'(m_req),    32'd0);
        chk("none_ready", 32'(st_ready), 32'd1);

        // sw at 0x10 without ack: timeout after 16 request cycles.
        drive(2'b11, 32'h0000_0010, 32'hCAFE_F00D);
        tick();
        idle_in();
        chk("to_byteen", 32'(m_byteen), 32'hF);
        chk("to_wdata",  m_wdata,       32'hCAFE_F00D);
        hi_cnt   = 0;
        err_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_req)   hi_cnt++;
            if (bus_err) err_cnt++;
            if (st_done) done_cnt++;
            tick();
        end
        chk("to_req_cycles", 32'(hi_cnt),   32'd16);
        chk("to_buserr_cnt", 32'(err_cnt),  32'd1);
        chk("to_done_cnt",   32'(done_cnt), 32'd0);
        chk("to_ready",      32'(st_ready), 32'd1);

        // Ack in the 16th BUSY cycle wins over the timeout; then back-to-back.
        drive(2'b11, 32'h0000_0020, 32'h0102_0304);
        tick();
        idle_in();
        for (int k = 1; k <= 16; k++) begin
            chk("lim_req_hi", 32'(m_req), 32'd1);
            if (k == 16) m_ack = 1'b1;
            tick();
        end
        m_ack = 1'b0;
        chk("lim_done",   32'(st_done),  32'd1);
        chk("lim_buserr", 32'(bus_err),  32'd0);
        chk("lim_req_lo", 32'(m_req),    32'd0);
        chk("lim_ready",  32'(st_ready), 32'd1);
        drive(2'b11, 32'h0000_0030, 32'h0A0B_0C0D);
        tick();
        idle_in();
        chk("b2b_req",    32'(m_req),    32'd1);
        chk("b2b_addr",   m_addr,        32'h0000_0030);
        chk("b2b_wdata",  m_wdata,       32'h0A0B_0C0D);
        chk("b2b_buserr", 32'(bus_err),  32'd0);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("b2b_done", 32'(st_done), 32'd1);

        // Reset during BUSY.
        tick();
        drive(2'b11, 32'h0000_0040, 32'h5555_AAAA);
        tick();
        idle_in();
        chk("rb_req_hi", 32'(m_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rb_req_async", 32'(m_req),    32'd0);
        chk("rb_ready",     32'(st_ready), 32'd1);
        tick();
        reset = 1'b1;
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            if (st_done) done_cnt++;
            if (bus_err) err_cnt++;
            tick();
        end
        chk("rb_no_done",   32'(done_cnt), 32'd0);
        chk("rb_no_buserr", 32'(err_cnt),  32'd0);
        m_ack = 1'b1;
        tick();
        tick();
        m_ack = 1'b0;
        chk("idle_ack_req",   32'(m_req),    32'd0);
        chk("idle_ack_done",  32'(st_done),  32'd0);
        chk("idle_ack_ready", 32'(st_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_req_unit.md
Name: store_req_unit

Overview:
- Store-side counterpart of the load-data extender: takes a store (sb/sh/sw) from the MEM stage and computes the 4-bit byte enable and the lane-aligned write data.
- Checks store alignment.
- Issues a single write request on the data bus with a req/ack handshake and a timeout.
- Sits between the MEM-stage pipeline register and the data-memory/bridge write port; the pipeline stalls on st_ready.

Parameters:
- TIMEOUT, 16: maximum number of cycles m_req stays high without m_ack before the transfer is aborted. Legal range is ≥2.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request present this cycle.
- st_type  input  2  store type: 00 none, 01 sb, 10 sh, 11 sw.
- st_addr  input  32  byte address of the store.
- st_wdata  input  32  register data; low byte or halfword used for sb/sh.
- st_ready  output  1  unit can accept a request; high only in IDLE.
- st_done  output  1  one-cycle pulse when the bus acknowledges the write.
- exc_ades  output  1  one-cycle pulse on a misaligned store (AdES).
- exc_addr  output  32  faulting address, held until the next exception.
- bus_err  output  1  one-cycle pulse on timeout abort.
- m_req  output  1  write request to the bus.
- m_addr  output  32  word address {st_addr[31:2],2'b00}.
- m_byteen  output  4  byte enables.
- m_wdata  output  32  lane-aligned write data.
- m_ack  input  1  bus write acknowledge.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - All outputs go to 0 except st_ready=1; timeout counter cleared.
  - Reset asserted mid-transfer drops m_req immediately and does not pulse st_done or bus_err.
- States: IDLE, BUSY. All outputs are registered except st_ready, which is a decode of the state (IDLE).
- Acceptance: in IDLE, a request is accepted when st_valid=1 and st_type≠00. st_valid with st_type=00 is ignored and causes no state change.
- Alignment check on acceptance:
  - sh is misaligned when addr[0]=1.
  - sw is misaligned when addr[1:0]≠00.
  - sb is never misaligned.
  - On a misaligned store: next cycle exc_ades=1 for one cycle and exc_addr=st_addr; state stays IDLE; m_req, m_byteen and m_wdata are not changed.
- Encoding for an aligned store (latched on acceptance, held through BUSY):
  - sb: byteen=4'b0001<<addr[1:0]; wdata=st_wdata[7:0] placed in byte lane addr[1:0], all other lanes 0.
  - sh, addr[1]=0: byteen=0011; wdata={16'd0, st_wdata[15:0]}.
  - sh, addr[1]=1: byteen=1100; wdata={st_wdata[15:0], 16'd0}.
  - sw: byteen=1111; wdata=st_wdata.
- Transition to BUSY: the cycle after acceptance, state=BUSY and m_req=1; the counter is cleared. m_addr, m_byteen and m_wdata stay stable while m_req=1.
- In BUSY:
  - m_ack=1 sampled at a rising edge: next cycle m_req=0, m_byteen=0, st_done=1 for one cycle, state=IDLE.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 and m_ack=0, then next cycle m_req=0, bus_err=1 for one cycle, state=IDLE. m_req is therefore high for exactly TIMEOUT cycles.
  - m_ack arriving in the same cycle as the timeout limit wins: st_done is pulsed, bus_err is not.
- m_ack while in IDLE is ignored.
- A new request can be accepted in the first IDLE cycle, i.e. the same cycle st_done or bus_err is high.
- Latency: acceptance at edge N; m_req high from edge N+1; st_done at edge N+2 at the earliest (m_ack high during the first BUSY cycle).

Test Plan:
- sb, addr=0x0000_1002, wdata=0xAABB_CCDD, m_ack tied 1 -> m_addr=0x0000_1000, m_byteen=0100, m_wdata=0x00DD_0000; m_req high 1 cycle; st_done pulses one cycle later.
- sh, addr=0x0000_0042, wdata=0x1234_5678, ack after 3 cycles -> m_byteen=1100, m_wdata=0x5678_0000; m_req high 3 cycles; st_ready=0 throughout BUSY.
- sw, addr=0x0000_0006 -> exc_ades one-cycle pulse, exc_addr=0x0000_0006, m_req never rises; sh at addr=0x0000_0003 gives the same result with exc_addr=0x0000_0003.
- sw, addr=0x0000_0010, m_ack held 0, TIMEOUT=16 -> m_req high exactly 16 cycles, then bus_err pulses once, st_done stays 0, st_ready=1 again.
- m_ack rises in the 16th BUSY cycle -> st_done=1, bus_err=0; back-to-back sw in the first IDLE cycle is accepted, and m_req returns after one low cycle.
- reset driven low during BUSY -> m_req=0 asynchronously; after release st_ready=1, no st_done or bus_err pulse; m_ack in IDLE has no effect.
